// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
// Holds the adder slice width, the sequencer state encoding and a word-slice helper.
// No logic of its own; imported by the sequencer.
package adder_pkg;

   // Width of one adder slice; tied to the CSAdder datapath width.
   localparam int WORD_W = 32;

   // Largest operand size the word_sel helper can address.
   localparam int MAX_WORDS = 64;
   localparam int MAX_DW    = MAX_WORDS * WORD_W;

   // Width of the word index accepted by word_sel.
   localparam int SEL_W = 8;

   // Sequencer states.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Return word 'idx' (least-significant word = 0) of a zero-extended operand.
   function automatic logic [WORD_W-1:0] word_sel(input logic [MAX_DW-1:0] vec,
                                                  input logic [SEL_W-1:0]  idx);
      return vec[idx*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/CSAdder.sv
// 32-bit carry-select adder: q = a + b + cin, carry out on cout.
// Combinational, zero latency.
// No handshake; output follows inputs.
module CSAdder (
   input  logic        cin,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] q,
   output logic        cout
);

   localparam int BLK_W  = 8;
   localparam int N_BLKS = 32 / BLK_W;

   // Carry entering each block; c[N_BLKS] is the adder carry out.
   logic [N_BLKS:0] c;

   assign c[0] = cin;

   // Each block precomputes its sum for both possible incoming carries and the
   // real carry only steers a mux, so the carry path is one mux per block.
   for (genvar g = 0; g < N_BLKS; g++) begin : g_blk
      logic [BLK_W:0] s0;
      logic [BLK_W:0] s1;

      assign s0 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]};
      assign s1 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]}
                  + {{BLK_W{1'b0}}, 1'b1};

      assign q[g*BLK_W +: BLK_W] = c[g] ? s1[BLK_W-1:0] : s0[BLK_W-1:0];
      assign c[g+1]              = c[g] ? s1[BLK_W]     : s0[BLK_W];
   end

   assign cout = c[N_BLKS];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: steps one 32-bit word per clock through one CSAdder, LSW first.
// Latency: start accepted at edge E -> done pulse in the cycle after edge E+N_WORDS.
// No queuing: start is only sampled in IDLE/DONE; held start gives one result per N_WORDS+1 cycles.
module mp_add_seq
   import adder_pkg::*;
#(
   parameter int N_WORDS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        sub,
   input  logic                        cin,
   input  logic [N_WORDS*WORD_W-1:0]   a,
   input  logic [N_WORDS*WORD_W-1:0]   b,
   output logic                        busy,
   output logic                        done,
   output logic [N_WORDS*WORD_W-1:0]   q,
   output logic                        cout,
   output logic                        ovf
);

   localparam int DW    = N_WORDS * WORD_W;
   localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   // N_WORDS must not exceed MAX_WORDS so word_sel can address every word.

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic               sub_reg;
   logic [DW-1:0]      a_reg;
   logic [DW-1:0]      b_reg;
   logic [DW-1:0]      acc;

   logic [MAX_DW-1:0]  a_ext;
   logic [MAX_DW-1:0]  b_ext;
   logic [WORD_W-1:0]  a_word;
   logic [WORD_W-1:0]  b_word;
   logic [WORD_W-1:0]  b_op;
   logic [WORD_W-1:0]  sum_word;
   logic               add_cout;
   logic               last_word;
   logic               ovf_word;
   logic [DW-1:0]      acc_final;

   // Operand words for the current index; subtraction feeds the inverted B word
   // and relies on the carry register having been preset to 1 at accept.
   assign a_ext  = MAX_DW'(a_reg);
   assign b_ext  = MAX_DW'(b_reg);
   assign a_word = word_sel(a_ext, SEL_W'(idx));
   assign b_word = word_sel(b_ext, SEL_W'(idx));
   assign b_op   = sub_reg ? ~b_word : b_word;

   assign last_word = (idx == IDX_W'(N_WORDS - 1));

   // Signed overflow is only meaningful on the top word; it is sampled when
   // last_word is set.
   assign ovf_word = (a_word[WORD_W-1] == b_op[WORD_W-1]) &&
                     (sum_word[WORD_W-1] != a_word[WORD_W-1]);

   CSAdder u_slice (
      .cin  (carry),
      .a    (a_word),
      .b    (b_op),
      .q    (sum_word),
      .cout (add_cout)
   );

   // Accumulator with the word being produced this cycle merged in, so the
   // final result can be registered onto q on the same edge as the top word.
   always_comb begin
      acc_final = acc;
      acc_final[idx*WORD_W +: WORD_W] = sum_word;
   end

   // Sequencer FSM: accept, step words through the slice, publish the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         carry   <= 1'b0;
         sub_reg <= 1'b0;
         a_reg   <= '0;
         b_reg   <= '0;
         acc     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         q       <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_reg   <= a;
                  b_reg   <= b;
                  sub_reg <= sub;
                  // a - b is a + ~b + 1, so subtraction starts with carry 1.
                  carry   <= sub | cin;
                  idx     <= '0;
                  state   <= S_RUN;
                  busy    <= 1'b1;
               end else begin
                  state   <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            S_RUN: begin
               acc[idx*WORD_W +: WORD_W] <= sum_word;
               carry <= add_cout;
               idx   <= idx + IDX_W'(1);
               if (last_word) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  q     <= acc_final;
                  cout  <= add_cout;
                  ovf   <= ovf_word;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: directed corner cases plus random back-to-back traffic.
// Expected results are queued at issue time and popped by a monitor on each done pulse.
// Reference model uses plain wide unsigned/signed arithmetic.
module tb_mp_add_seq;

   localparam int N_WORDS = 4;
   localparam int DW      = N_WORDS * 32;

   typedef struct {
      logic [DW-1:0] q;
      logic          cout;
      logic          ovf;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          sub;
   logic          cin;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          busy;
   logic          done;
   logic [DW-1:0] q;
   logic          cout;
   logic          ovf;

   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   mp_add_seq #(.N_WORDS(N_WORDS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .cin   (cin),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .cout  (cout),
      .ovf   (ovf)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Behavioural reference: unsigned result modulo 2^DW, carry/no-borrow, and
   // signed overflow as "true signed result outside the DW-bit range".
   function automatic exp_t ref_model(input logic [DW-1:0] ta, input logic [DW-1:0] tb_,
                                      input logic tcin, input logic tsub);
      exp_t r;
      logic [DW:0]          full;
      logic signed [DW+1:0] sa, sb, sc, sr, smax, smin;
      sa   = $signed({{2{ta[DW-1]}}, ta});
      sb   = $signed({{2{tb_[DW-1]}}, tb_});
      sc   = '0;
      sc[0] = tcin;
      smax = $signed({3'b000, {(DW-1){1'b1}}});
      smin = -smax - sc - $signed({{(DW+1){1'b0}}, 1'b1}) + sc;
      if (tsub) begin
         full   = {1'b0, ta} - {1'b0, tb_};
         r.q    = full[DW-1:0];
         r.cout = (ta >= tb_);
         sr     = sa - sb;
      end else begin
         full   = {1'b0, ta} + {1'b0, tb_} + {{DW{1'b0}}, tcin};
         r.q    = full[DW-1:0];
         r.cout = full[DW];
         sr     = sa + sb + sc;
      end
      r.ovf = (sr > smax) || (sr < smin);
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_wide();
      logic [DW-1:0] v;
      for (int w = 0; w < N_WORDS; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest pending result.
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 required no pending result");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("q",    q,          e.q);
            check("cout", DW'(cout),  DW'(e.cout));
            check("ovf",  DW'(ovf),   DW'(e.ovf));
         end
      end
   end

   // Issue one operation (called just after a falling edge, DUT idle), push its
   // expected result, and check done latency and busy duration.
   task automatic do_op(input string name, input logic [DW-1:0] ta, input logic [DW-1:0] tb_,
                        input logic tcin, input logic tsub,
                        input logic [DW-1:0] eq, input logic ecout, input logic eovf,
                        input bit inject);
      exp_t e;
      int   lat;
      int   busy_cnt;
      e.q = eq; e.cout = ecout; e.ovf = eovf;
      exp_q.push_back(e);
      a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
      lat = 0;
      busy_cnt = 0;
      while (lat <= 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) start = 1'b0;
         if (inject && lat == 2) begin
            start = 1'b1; a = ~ta; b = ta; sub = ~tsub; cin = ~tcin;
         end
         if (inject && lat == 3) start = 1'b0;
         if (done) break;
         if (busy) busy_cnt++;
      end
      check({name, "_latency"}, DW'(lat), DW'(N_WORDS + 1));
      check({name, "_busy_cycles"}, DW'(busy_cnt), DW'(N_WORDS));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0] ones, msb, maxpos;
      ones   = '1;
      msb    = '0;
      msb[DW-1] = 1'b1;
      maxpos = ~msb;

      // Reset held two cycles with start asserted: outputs cleared, nothing accepted.
      rst = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b1; a = ones; b = ones;
      repeat (2) begin
         @(negedge clk);
         check("rst_busy", DW'(busy), '0);
         check("rst_done", DW'(done), '0);
         check("rst_q",    q,         '0);
         check("rst_cout", DW'(cout), '0);
         check("rst_ovf",  DW'(ovf),  '0);
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("post_rst_idle_busy", DW'(busy), '0);

      // Full carry ripple across all words.
      do_op("ripple", ones, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      // Borrow through all words, then a simple no-borrow subtract.
      do_op("sub_borrow", '0, DW'(1), 1'b0, 1'b1, ones, 1'b0, 1'b0, 1'b0);
      do_op("sub_5_3", DW'(5), DW'(3), 1'b0, 1'b1, DW'(2), 1'b1, 1'b0, 1'b0);
      // cin must be ignored for subtract.
      do_op("sub_cin_ign", DW'(5), DW'(3), 1'b1, 1'b1, DW'(2), 1'b1, 1'b0, 1'b0);
      // Signed overflow in both directions.
      do_op("ovf_pos", maxpos, DW'(1), 1'b0, 1'b0, msb, 1'b0, 1'b1, 1'b0);
      do_op("ovf_neg", msb, ones, 1'b0, 1'b0, maxpos, 1'b1, 1'b1, 1'b0);
      // Start during RUN with different operands is ignored.
      do_op("start_in_run", DW'(5), DW'(3), 1'b0, 1'b0, DW'(8), 1'b0, 1'b0, 1'b1);

      // Abort at idx=2: busy drops, q cleared, no done pulse.
      a = ones; b = DW'(7); sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("abort_busy", DW'(busy), '0);
      check("abort_done", DW'(done), '0);
      check("abort_q",    q,         '0);
      rst = 1'b0;
      do_op("after_abort", DW'(100), DW'(23), 1'b1, 1'b0, DW'(124), 1'b0, 1'b0, 1'b0);

      // Random back-to-back traffic with start held high.
      begin
         logic [DW-1:0] ra, rb;
         logic          rc, rs;
         int            cnt;
         ra = rand_wide(); rb = rand_wide(); rc = 1'($urandom); rs = 1'($urandom);
         a = ra; b = rb; cin = rc; sub = rs; start = 1'b1;
         exp_q.push_back(ref_model(ra, rb, rc, rs));
         for (int n = 0; n < 500; n++) begin
            cnt = 0;
            do begin
               @(negedge clk);
               cnt++;
            end while (!done && cnt < 20);
            check("b2b_period", DW'(cnt), DW'(N_WORDS + 1));
            if (!done) break;
            if (n < 499) begin
               ra = rand_wide();
               case ($urandom_range(0, 3))
                  0: rb = ~ra;
                  1: rb = ra;
                  default: rb = rand_wide();
               endcase
               rc = 1'($urandom); rs = 1'($urandom);
               a = ra; b = rb; cin = rc; sub = rs;
               exp_q.push_back(ref_model(ra, rb, rc, rs));
            end else begin
               start = 1'b0;
            end
         end
         start = 1'b0;
      end

      repeat (10) @(negedge clk);
      check("scoreboard_drained", DW'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
